instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the simple CPU, directly upstream of the control unit. Holds the program counter, fetches 16-bit instructions from instruction memory over a req/valid handshake, and latches them into an instruction register. Presents the decoded fields (opcode to the control unit; rd/rs1/rs2 to the register file) with a valid/stall handshake. Stops permanently on a HALT opcode.

## Interface
- ADDR_W, 8: instruction memory address width (word addressed); PC width.
- INSTR_W, 16: instruction width; fixed format [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; sampled in IDLE and at the end of ISSUE.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_rdata  in  INSTR_W  instruction word; qualified by imem_valid.
- imem_valid  in  1  memory response; may arrive in the same cycle as imem_req or later.
- stall  in  1  downstream not ready; holds the issued instruction.
- opcode  out  4  to the control unit; 4'hF (NOP) whenever instr_valid=0.
- rd, rs1, rs2  out  4 each  register fields from the instruction register.
- instr_valid  out  1  the instruction on the outputs is live.
- pc  out  ADDR_W  address of the next fetch.
- halted  out  1  HALT was fetched; sticky until reset.

## Operation
- States: IDLE, FETCH, ISSUE, HALTED (shared enum).
- IDLE: en=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid, capture imem_rdata into the IR and set pc <= pc+1 (mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0).
  - If the captured opcode is 4'hE (HALT), go to HALTED.
  - Otherwise go to ISSUE.
- en going low during FETCH does not abort the fetch.
- ISSUE: instr_valid=1. The instruction is consumed on a cycle where instr_valid=1 and stall=0.
  - On consumption: en=1 -> FETCH; en=0 -> IDLE.
  - While stall=1, the IR, pc and all outputs hold.
- HALTED: halted=1, imem_req=0, instr_valid=0. Exit only by reset. The HALT instruction is never issued downstream.
- imem_valid outside FETCH is ignored; imem_rdata does not change the IR.
- opcode = instr_valid ? IR[15:12] : 4'hF, so reg_write_en stays low between instructions. rd/rs1/rs2 come directly from the IR.
- Opcodes 4'h8–4'hD are not trapped; they pass through (the control unit treats them as NOP).
- Reset values:
  - State IDLE; IR=16'hF000; pc=0.
  - imem_req=0, imem_addr=0, instr_valid=0, halted=0.
  - opcode=4'hF; rd=rs1=rs2=0.

## Timing
- All state, IR and pc are registered. imem_req, instr_valid and halted decode from registered state, with no combinational path from inputs.
- imem_addr and opcode are combinational from registers only.
- Zero-wait memory case:
  - en high in cycle 0 (IDLE) -> imem_req in cycle 1.
  - imem_valid in cycle 1 -> instr_valid in cycle 2.
  - With stall=0, the next imem_req is in cycle 3. Peak throughput is one instruction per 2 cycles.
- Each memory wait cycle adds one cycle; imem_addr is stable throughout.
- halted rises the cycle after imem_valid returns HALT.
- Reset asserted mid-operation, in any state, forces reset values immediately (asynchronous), including dropping an outstanding imem_req. A late imem_valid after reset is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams INST_ADD..INST_NOT, INST_HALT=4'hE, INST_NOP=4'hF;
  - field bit positions (OPC_HI/LO, RD, RS1, RS2);
  - the fetch state enum.
- The control unit should move to cpu_pkg for its opcodes.
- Single module, no sub-modules. The PC incrementer is one line and does not justify a separate pc_reg.

## Test plan
- Reset: hold rst_n=0 with en=1 and random imem inputs -> all outputs at reset values, opcode=4'hF.
- Zero-wait program {16'h0123, 16'h1456, 16'hE000} at addresses 0..2, stall=0:
  - instr_valid pulses with opcode 0 then 1; (rd, rs1, rs2) = (1,2,3) then (4,5,6);
  - pc sequence 1, 2, 3; halted=1 after the third fetch;
  - imem_req never rises again; opcode never shows 4'hE.
- Wait states: imem_valid 3 cycles after imem_req -> imem_req and imem_addr held for 4 cycles; instr_valid the cycle after valid.
- Stall: stall=1 for 4 cycles while issuing 16'h2789 -> opcode=2, rd=7 held; no imem_req. Release -> FETCH at the next pc.
- Wrap: start at pc=8'hFE (preload via a sequence of NOPs or force) -> fetches at FE, FF, then 00; pc wraps to 0.
- Reset mid-FETCH with imem_valid withheld -> imem_req drops asynchronously, pc=0. A following late imem_valid is ignored; restart fetches from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fixed instruction field layout, fetch-stage states.
package cpu_pkg;

  localparam logic [3:0] INST_ADD  = 4'h0;
  localparam logic [3:0] INST_SUB  = 4'h1;
  localparam logic [3:0] INST_AND  = 4'h2;
  localparam logic [3:0] INST_OR   = 4'h3;
  localparam logic [3:0] INST_XOR  = 4'h4;
  localparam logic [3:0] INST_SHL  = 4'h5;
  localparam logic [3:0] INST_SHR  = 4'h6;
  localparam logic [3:0] INST_NOT  = 4'h7;
  localparam logic [3:0] INST_HALT = 4'hE;
  localparam logic [3:0] INST_NOP  = 4'hF;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS1_HI = 7;
  localparam int unsigned RS1_LO = 4;
  localparam int unsigned RS2_HI = 3;
  localparam int unsigned RS2_LO = 0;

  // Reset IR holds a NOP so nothing downstream decodes a write.
  localparam logic [15:0] IR_RESET = 16'hF000;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_ISSUE,
    FS_HALTED
  } fetch_state_e;

  function automatic logic [3:0] instr_opcode(input logic [15:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC, instruction register and IDLE/FETCH/ISSUE/HALTED sequencing
// with a valid/stall handoff to decode and a sticky stop on HALT.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  instr_fetch_if.master     imem,
  input  logic              stall,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      ir_q    <= INSTR_W'(IR_RESET);
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    unique case (state_q)
      FS_IDLE: begin
        if (en) state_d = FS_FETCH;
      end
      FS_FETCH: begin
        // en is deliberately ignored here: a started fetch always completes.
        if (imem.imem_valid) begin
          ir_d = imem.imem_rdata;
          pc_d = pc_q + ADDR_W'(1);
          if (instr_opcode(imem.imem_rdata[15:0]) == INST_HALT) state_d = FS_HALTED;
          else                                                   state_d = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (!stall) state_d = en ? FS_FETCH : FS_IDLE;
      end
      FS_HALTED: begin
        state_d = FS_HALTED;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == FS_FETCH);
  assign imem.imem_addr = pc_q;

  assign instr_valid = (state_q == FS_ISSUE);
  assign halted      = (state_q == FS_HALTED);
  assign pc          = pc_q;

  // Forcing NOP outside ISSUE keeps reg_write_en low between instructions.
  assign opcode = instr_valid ? ir_q[OPC_HI:OPC_LO] : INST_NOP;
  assign rd     = ir_q[RD_HI:RD_LO];
  assign rs1    = ir_q[RS1_HI:RS1_LO];
  assign rs2    = ir_q[RS2_HI:RS2_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: memory responder plus transaction-level
// program-order scoreboard, with directed timing scenarios.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] opcode, rd, rs1, rs2;
  logic       instr_valid, halted;
  logic [7:0] pc;

  instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) imem ();

  instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .imem(imem), .stall(stall),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Program memory and reference model state
  logic [15:0] mem [256];
  logic [7:0]  exp_pc;
  logic        pend_valid;
  logic [15:0] pend_word;
  logic        exp_halt;
  logic        req_must_hold;
  int          wait_cnt, cyc, fetch_cnt, stall_cnt, halt_cycles;
  int          req_rise[$], iv_rise[$];
  logic [3:0]  issued_opc[$];
  logic        prev_req, prev_iv;
  logic [7:0]  hist0, hist1;
  bit          saw_wrap;
  int          lat_mode, stall_mode, en_mode;
  bit          spurious, wrap_mode;

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == INST_HALT) w[15:12] = INST_NOP;
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
  endtask

  task automatic model_reset();
    exp_pc = '0; pend_valid = 1'b0; pend_word = '0; exp_halt = 1'b0;
    req_must_hold = 1'b0; wait_cnt = -1; cyc = -1; fetch_cnt = 0;
    stall_cnt = 0; halt_cycles = 0;
    req_rise.delete(); iv_rise.delete(); issued_opc.delete();
    prev_req = 1'b0; prev_iv = 1'b0; hist0 = '0; hist1 = '0; saw_wrap = 0;
  endtask

  task automatic do_reset(input bit check_vals);
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem.imem_valid = 1'($urandom);
      imem.imem_rdata = 16'($urandom);
      stall = 1'($urandom);
      if (check_vals) begin
        check_eq("rst_req", imem.imem_req, 1'b0);
        check_eq("rst_addr", imem.imem_addr, 8'h00);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_opcode", opcode, 4'hF);
        check_eq("rst_rd", rd, 4'h0);
        check_eq("rst_rs1", rs1, 4'h0);
        check_eq("rst_rs2", rs2, 4'h0);
        check_eq("rst_pc", pc, 8'h00);
      end
    end
    en = 1'b0; stall = 1'b0; imem.imem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    logic        stall_n, en_n;
    logic [15:0] w;
    @(negedge clk);
    cyc++;
    check_eq("halted", halted, exp_halt);
    check_eq("instr_valid", instr_valid, pend_valid);
    if (pend_valid) begin
      check_eq("opcode", opcode, pend_word[15:12]);
      check_eq("rd", rd, pend_word[11:8]);
      check_eq("rs1", rs1, pend_word[7:4]);
      check_eq("rs2", rs2, pend_word[3:0]);
      check_eq("pc_issue", pc, exp_pc);
    end else begin
      check_eq("opcode_nop", opcode, INST_NOP);
    end
    if (exp_halt || pend_valid) check_eq("req_quiet", imem.imem_req, 1'b0);
    if (req_must_hold) check_eq("req_hold", imem.imem_req, 1'b1);
    if (imem.imem_req) check_eq("imem_addr", imem.imem_addr, exp_pc);
    if (exp_halt) halt_cycles++;
    if (imem.imem_req && !prev_req) req_rise.push_back(cyc);
    if (instr_valid && !prev_iv) iv_rise.push_back(cyc);
    prev_req = imem.imem_req;
    prev_iv  = instr_valid;

    case (stall_mode)
      1:       stall_n = ($urandom_range(0, 2) == 0);
      2:       stall_n = pend_valid && (stall_cnt < 4);
      default: stall_n = 1'b0;
    endcase
    if (pend_valid && stall_n) stall_cnt++;
    if (pend_valid && !stall_n) begin
      issued_opc.push_back(pend_word[15:12]);
      pend_valid = 1'b0;
      stall_cnt = 0;
    end
    en_n = (en_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);

    if (imem.imem_req) begin
      if (wait_cnt < 0) wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      if (wait_cnt == 0) begin
        imem.imem_valid = 1'b1;
        imem.imem_rdata = mem[imem.imem_addr];
        w = mem[exp_pc];
        if (hist1 == 8'hFE && hist0 == 8'hFF && exp_pc == 8'h00) saw_wrap = 1;
        hist1 = hist0;
        hist0 = exp_pc;
        exp_pc = exp_pc + 8'd1;
        fetch_cnt++;
        if (w[15:12] == INST_HALT) exp_halt = 1'b1;
        else begin pend_valid = 1'b1; pend_word = w; end
        req_must_hold = 1'b0;
        wait_cnt = -1;
      end else begin
        wait_cnt--;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = 16'($urandom);
        req_must_hold = 1'b1;
      end
    end else begin
      // Responses outside a fetch must be ignored by the stage.
      imem.imem_valid = spurious && ($urandom_range(0, 3) == 0);
      imem.imem_rdata = 16'($urandom);
      req_must_hold = 1'b0;
    end
    stall = stall_n;
    en = en_n;
  endtask

  task automatic run(input int budget);
    bit done = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (wrap_mode && fetch_cnt == 256) mem[2] = 16'hE000;
      if (halt_cycles >= 3) begin done = 1; break; end
    end
    check_eq("run_done", done, 1'b1);
  endtask

  task automatic set_modes(input int lat, input int stl, input int enm, input bit spur, input bit wrp);
    lat_mode = lat; stall_mode = stl; en_mode = enm; spurious = spur; wrap_mode = wrp;
  endtask

  initial begin
    imem.imem_valid = 1'b0;
    imem.imem_rdata = '0;
    model_reset();

    // Reset values with en high and noisy memory inputs
    do_reset(1);

    // Zero-wait three-instruction program
    fill_mem();
    mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'hE000;
    do_reset(0);
    set_modes(0, 0, 1, 0, 0);
    run(60);
    check_eq("zw_nreq", req_rise.size(), 3);
    check_eq("zw_niss", issued_opc.size(), 2);
    if (req_rise.size() >= 2 && iv_rise.size() >= 1) begin
      check_eq("zw_req0", req_rise[0], 1);
      check_eq("zw_iv0", iv_rise[0], 2);
      check_eq("zw_req1", req_rise[1], 3);
    end
    if (issued_opc.size() == 2) begin
      check_eq("zw_op0", issued_opc[0], 4'h0);
      check_eq("zw_op1", issued_opc[1], 4'h1);
    end
    check_eq("zw_pc_end", pc, 8'h03);

    // Three memory wait states
    fill_mem();
    mem[1] = 16'hE000;
    do_reset(0);
    set_modes(3, 0, 1, 0, 0);
    run(60);
    if (req_rise.size() >= 1 && iv_rise.size() >= 1) begin
      check_eq("ws_req0", req_rise[0], 1);
      check_eq("ws_iv_lat", iv_rise[0] - req_rise[0], 4);
    end else check_eq("ws_events", req_rise.size() + iv_rise.size(), 2);

    // Downstream stall for four cycles
    fill_mem();
    mem[0] = 16'h2789; mem[1] = 16'hE000;
    do_reset(0);
    set_modes(0, 2, 1, 0, 0);
    run(60);
    if (req_rise.size() >= 2 && iv_rise.size() >= 1) begin
      check_eq("st_iv0", iv_rise[0], 2);
      check_eq("st_req1", req_rise[1], 7);
    end else check_eq("st_events", req_rise.size(), 2);
    if (issued_opc.size() >= 1) check_eq("st_op", issued_opc[0], 4'h2);

    // Long random run through the PC wrap, HALT placed at 8'h02 on the second pass
    fill_mem();
    do_reset(0);
    set_modes(-1, 1, 0, 1, 1);
    run(6000);
    check_eq("wrap_seen", saw_wrap, 1'b1);
    check_eq("wrap_pc_end", pc, 8'h03);

    // Reset while a fetch is outstanding, then a late response
    fill_mem();
    mem[30] = 16'hE000;
    do_reset(0);
    @(negedge clk);
    en = 1'b1;
    imem.imem_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem.imem_req) break;
    end
    check_eq("mf_req_before", imem.imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mf_req_async", imem.imem_req, 1'b0);
    check_eq("mf_pc_async", pc, 8'h00);
    check_eq("mf_addr_async", imem.imem_addr, 8'h00);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    imem.imem_valid = 1'b1;
    imem.imem_rdata = 16'h3ABC;
    @(negedge clk);
    imem.imem_valid = 1'b0;
    check_eq("late_req", imem.imem_req, 1'b0);
    check_eq("late_opcode", opcode, 4'hF);
    check_eq("late_rd", rd, 4'h0);
    check_eq("late_rs1", rs1, 4'h0);
    check_eq("late_rs2", rs2, 4'h0);
    check_eq("late_pc", pc, 8'h00);
    model_reset();
    set_modes(-1, 1, 0, 1, 0);
    run(1000);
    check_eq("mf_pc_end", pc, 8'd31);

    // A few more random programs with HALT at a random address
    for (int k = 0; k < 3; k++) begin
      int unsigned hpos;
      fill_mem();
      hpos = $urandom_range(1, 40);
      mem[hpos] = 16'hE000;
      do_reset(0);
      set_modes(-1, 1, 0, 1, 0);
      run(1500);
      check_eq("rnd_pc_end", pc, 8'(hpos + 1));
      check_eq("rnd_issued", issued_opc.size(), hpos);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
